// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB requester.
//   apb_state_t : requester FSM states
//   APB_ADDR_W  : default address width
//   APB_DATA_W  : default data width
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command port, response port and APB bus of the requester.
//   modport master : the requester (drives cmd_ready, rsp_*, PSELx/PENABLE/PWRITE/PADDR/PWDATA)
//   modport slave  : sequencer + APB responder side (drives cmd_*, rsp_ready, PREADY/PSLVERR/PRDATA)
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PREADY, PSLVERR, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PREADY, PSLVERR, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS wait cycles (PREADY low) and flags the limit.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : restart the count (new transfer accepted)
//   en_i           : count this cycle (ACCESS with PREADY low)
//   expired_o      : this enabled cycle brings the count to LIMIT
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires on the cycle whose increment would make the count equal LIMIT,
    // so the transfer leaves ACCESS after exactly LIMIT low-PREADY cycles.
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master: APB requester. Takes one command per valid/ready handshake,
// runs the APB SETUP and ACCESS phases, and returns PRDATA/PSLVERR on a
// valid/ready response port.
//   PCLK, PRESETn : clock, async active-low reset
//   bus (master)  : command port, response port, APB bus
// Optional macro APB_TIMEOUT_EN: abort ACCESS with rsp_error=1 after
// timeout_cycles wait cycles (apb_wait_timer). Undefined: waits forever.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned addr_width     = APB_ADDR_W,
    parameter int unsigned data_width     = APB_DATA_W,
    parameter int unsigned timeout_cycles = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_master_if.master  bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]            state_q, state_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [addr_width-1:0] cmd_addr_q, cmd_addr_d;
    logic [data_width-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    logic cmd_ready;
    logic accept;
    logic tmo_expired;

    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
    assign accept    = bus.cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT (timeout_cycles)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_n_i   (PRESETn),
        .clr_i     (accept),
        .en_i      ((state_q == ST_ACCESS) && !bus.PREADY),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (timeout_cycles == 0);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY takes priority over a timeout landing on the same cycle.
                if (bus.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus.PSLVERR;
                    rsp_rdata_d = cmd_write_q ? '0 : bus.PRDATA;
                    state_d     = ST_RESP;
                end else if (tmo_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new command may be taken in IDLE or in the cycle the response is consumed.
        if (accept) begin
            state_d     = ST_SETUP;
            cmd_write_d = bus.cmd_write;
            cmd_addr_d  = bus.cmd_addr;
            cmd_wdata_d = bus.cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // APB outputs come only from registered state, never from inputs.
    assign bus.PSELx     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.PENABLE   = (state_q == ST_ACCESS);
    assign bus.PWRITE    = cmd_write_q;
    assign bus.PADDR     = cmd_addr_q;
    assign bus.PWDATA    = cmd_wdata_q;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that originates the transfers consumed by apb_controller.
- Accepts one command per handshake from a local command port and drives PSELx/PENABLE/PADDR/PWDATA/PWRITE through the APB SETUP and ACCESS phases.
- Waits for PREADY, then returns PRDATA/PSLVERR on a response port with valid/ready backpressure.
- Sits between the test or system sequencer and apb_controller.

Parameters:
- addr_width, 4: APB address width (PADDR, cmd_addr).
- data_width, 128: APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata).
- timeout_cycles, 16: maximum number of ACCESS cycles with PREADY low. Used only under APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  clock, rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  addr_width  transfer address.
- cmd_wdata  input  data_width  write data.
- rsp_valid  output  1  response held valid.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  data_width  read data; 0 for writes.
- rsp_error  output  1  PSLVERR, or timeout when the feature is enabled.
- PSELx  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  addr_width  APB address.
- PWDATA  output  data_width  APB write data.
- PREADY  input  1  responder ready.
- PSLVERR  input  1  responder error.
- PRDATA  input  data_width  responder read data.

Behaviour:
- One clock (PCLK). Reset is asynchronous and active-low (PRESETn).
- Reset values: state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- Command handshake:
  - cmd_ready = (state==IDLE) | (state==RESP & rsp_ready).
  - On cmd_valid & cmd_ready, register cmd_write/cmd_addr/cmd_wdata; the next state is SETUP.
- States:
  - IDLE: PSELx=0, PENABLE=0. cmd_valid -> SETUP, else stay in IDLE.
  - SETUP: PSELx=1, PENABLE=0, address/data/direction from the command registers. Always -> ACCESS after exactly one cycle.
  - ACCESS: PSELx=1, PENABLE=1. PADDR, PWDATA and PWRITE are held stable.
    - PREADY=1: capture PSLVERR into rsp_error; capture PRDATA into rsp_rdata if read, else rsp_rdata=0; set rsp_valid=1; -> RESP.
    - PREADY=0: stay in ACCESS (wait state).
  - RESP: PSELx=0, PENABLE=0, rsp_valid=1, rsp_rdata and rsp_error stable.
    - rsp_ready=1 with cmd_valid=1: accept the new command, clear rsp_valid, -> SETUP.
    - rsp_ready=1 with cmd_valid=0: clear rsp_valid, -> IDLE.
    - rsp_ready=0: hold.
- Latency: command accepted at cycle N; SETUP at N+1; ACCESS at N+2; rsp_valid at N+3 with zero wait states. Add one cycle per PREADY-low ACCESS cycle.
- Back-to-back throughput: one transfer per 3 cycles with rsp_ready tied high. PSELx drops for exactly one cycle (RESP) between transfers.
- APB outputs are decoded from the state register and the command registers only; they never depend combinationally on the inputs.
- PSLVERR and PRDATA are ignored except in the ACCESS cycle where PREADY=1.
- Reset mid-operation: immediate return to the reset values. The in-flight command is dropped and no response is produced.
- cmd_valid in SETUP or ACCESS is not accepted (cmd_ready=0); the sequencer must hold it.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An ACCESS wait counter of width $clog2(timeout_cycles+1) clears on entry to SETUP.
  - It increments on each ACCESS cycle with PREADY=0.
  - When it reaches timeout_cycles with PREADY still 0: rsp_error=1, rsp_rdata=0, rsp_valid=1, -> RESP, PSELx and PENABLE drop the next cycle.
  - If PREADY=1 and the limit are reached on the same cycle, PREADY wins and the normal response is returned.
- Undefined: no counter is present, ACCESS waits indefinitely, and timeout_cycles is unused.

Decomposition:
- Package apb_pkg holds:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - localparams for the default address and data widths.
- Sub-module apb_wait_timer: the timeout counter with clear, enable and expired signals, instantiated only under APB_TIMEOUT_EN.
- The FSM and the command/response registers stay in apb_master.

Test Plan:
- Write, addr=4'h3, wdata=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, PREADY=1 -> SETUP N+1, ACCESS N+2, rsp_valid at N+3, rsp_error=0, rsp_rdata=0.
- Read, addr=4'hA, PRDATA=128'hDEAD_BEEF_..._CAFE, PREADY low 3 cycles then high -> ACCESS lasts 4 cycles with PADDR stable, rsp_rdata=PRDATA, rsp_valid at N+6.
- Read with PSLVERR=1 on the PREADY cycle -> rsp_error=1. PSLVERR=1 on wait cycles alone does not set rsp_error.
- Two back-to-back commands, rsp_ready=1 -> second SETUP in the cycle after RESP, PSELx low for exactly 1 cycle, 3-cycle spacing.
- rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no APB activity. Release -> the next command proceeds.
- PRESETn asserted in ACCESS -> all outputs 0 immediately, no response. With APB_TIMEOUT_EN and timeout_cycles=16, PREADY stuck at 0 -> rsp_error=1 after 16 ACCESS cycles.
